// File: rtl/scancode_frame_queue.sv
// scancode_frame_queue: queues key-release scancodes and re-issues one per v_sync rise (gate=1) or one per cycle (gate=0).
// No backpressure: a push to a full queue is dropped and sets sticky overflow. Optional macro ESC_FLUSH_EN: Esc flushes the queue and emits 8'h45.
module scancode_frame_queue #(
  parameter int DEPTH  = 8,
  parameter int AW     = 3,
  parameter int CODE_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [CODE_W-1:0] scancode,
  input  logic              flag,
  input  logic              v_sync,
  input  logic              gate,
  input  logic              clear,
  output logic [CODE_W-1:0] out_code,
  output logic              out_flag,
  output logic [AW:0]       count,
  output logic              overflow
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [CODE_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              vs_d;
  logic              tick;
  logic              empty;
  logic              full;
  logic              pop;
  logic              esc;
  logic              push_ok;
  logic              drop;

  assign empty = (count == '0);
  assign full  = (count == FULL_CNT);
  assign tick  = v_sync & ~vs_d;
  assign pop   = ~empty & (gate ? tick : 1'b1);

`ifdef ESC_FLUSH_EN
  localparam logic [CODE_W-1:0] ESC_CODE   = CODE_W'(8'h76);
  localparam logic [CODE_W-1:0] RESET_CODE = CODE_W'(8'h45);
  assign esc = flag & (scancode == ESC_CODE);
`else
  assign esc = 1'b0;
`endif

  // A pop frees a slot on the same edge, so a full queue still accepts the push.
  assign push_ok = flag & ~esc & (~full | pop);
  assign drop    = flag & ~esc & full & ~pop;

  always_ff @(posedge clk) begin
    if (push_ok && !clear) begin
      mem[wr_ptr] <= scancode;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vs_d     <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      out_code <= '0;
      out_flag <= 1'b0;
    end else begin
      vs_d <= v_sync;
      if (clear) begin
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        count    <= '0;
        overflow <= 1'b0;
        out_flag <= 1'b0;
      end else if (esc) begin
`ifdef ESC_FLUSH_EN
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        count    <= '0;
        overflow <= 1'b0;
        out_code <= RESET_CODE;
        out_flag <= 1'b1;
`endif
      end else begin
        if (push_ok) begin
          wr_ptr <= wr_ptr + 1'b1;
        end
        if (pop) begin
          out_code <= mem[rd_ptr];
          rd_ptr   <= rd_ptr + 1'b1;
          out_flag <= 1'b1;
        end else begin
          out_flag <= 1'b0;
        end
        case ({push_ok, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
        if (drop) begin
          overflow <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_scancode_frame_queue.sv
// Directed bench for scancode_frame_queue: reset, frame gating, overflow, full push+pop, wrap-around, Esc handling.
module tb_scancode_frame_queue;

  logic       clk;
  logic       reset;
  logic [7:0] scancode;
  logic       flag;
  logic       v_sync;
  logic       gate;
  logic       clear;
  logic [7:0] out_code;
  logic       out_flag;
  logic [3:0] count;
  logic       overflow;

  int vectors = 0;
  int errs    = 0;

  scancode_frame_queue #(.DEPTH(8), .AW(3), .CODE_W(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .scancode (scancode),
    .flag     (flag),
    .v_sync   (v_sync),
    .gate     (gate),
    .clear    (clear),
    .out_code (out_code),
    .out_flag (out_flag),
    .count    (count),
    .overflow (overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish, required finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 ns after each rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] code);
    flag = 1'b1;
    scancode = code;
    step();
    flag = 1'b0;
  endtask

  task automatic frame(input string tag, input logic [7:0] exp_code);
    v_sync = 1'b1;
    step();
    chk({tag, "_flag"}, 32'(out_flag), 32'd1);
    chk({tag, "_code"}, 32'(out_code), 32'(exp_code));
    step();
    chk({tag, "_pulse"}, 32'(out_flag), 32'd0);
    v_sync = 1'b0;
    step();
  endtask

  initial begin
    logic [7:0] seq3 [3];
    seq3[0] = 8'h16; seq3[1] = 8'h2d; seq3[2] = 8'h21;

    reset = 1'b0; scancode = 8'h55; flag = 1'b1; v_sync = 1'b0; gate = 1'b0; clear = 1'b0;

    // Reset held with activity on the inputs
    for (int i = 0; i < 4; i++) begin
      v_sync = ~v_sync;
      step();
    end
    chk("rst_code", 32'(out_code), 32'd0);
    chk("rst_flag", 32'(out_flag), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    flag = 1'b0; v_sync = 1'b0;
    step();
    reset = 1'b1;
    step();

    // First push, ungated
    push(8'h16);
    chk("first_count", 32'(count), 32'd1);
    chk("first_noflag", 32'(out_flag), 32'd0);
    step();
    chk("first_flag", 32'(out_flag), 32'd1);
    chk("first_code", 32'(out_code), 32'h16);
    chk("first_drain", 32'(count), 32'd0);
    step();
    chk("first_pulse", 32'(out_flag), 32'd0);

    // Frame gating, v_sync held high for several cycles each frame
    gate = 1'b1;
    for (int i = 0; i < 3; i++) push(seq3[i]);
    chk("gate_count", 32'(count), 32'd3);
    chk("gate_noflag", 32'(out_flag), 32'd0);
    for (int i = 0; i < 3; i++) begin
      v_sync = 1'b1;
      step();
      chk("gate_flag", 32'(out_flag), 32'd1);
      chk("gate_code", 32'(out_code), 32'(seq3[i]));
      chk("gate_cnt_dec", 32'(count), 32'(2 - i));
      repeat (3) step();
      chk("gate_hold_flag", 32'(out_flag), 32'd0);
      chk("gate_hold_cnt", 32'(count), 32'(2 - i));
      v_sync = 1'b0;
      step();
    end
    chk("gate_empty", 32'(count), 32'd0);

    // Full and overflow
    for (int i = 1; i <= 9; i++) push(8'(i));
    chk("full_count", 32'(count), 32'd8);
    chk("full_ovf", 32'(overflow), 32'd1);
    for (int i = 1; i <= 8; i++) begin
      frame("drain", 8'(i));
      chk("drain_ovf", 32'(overflow), 32'd1);
    end
    chk("drain_empty", 32'(count), 32'd0);
    v_sync = 1'b1;
    step();
    chk("empty_tick_noflag", 32'(out_flag), 32'd0);
    chk("empty_tick_hold", 32'(out_code), 32'h08);
    v_sync = 1'b0;
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("clear_ovf", 32'(overflow), 32'd0);
    chk("clear_hold", 32'(out_code), 32'h08);

    // Full with push and pop on the same edge
    for (int i = 0; i < 8; i++) push(8'h31 + 8'(i));
    chk("fpp_fill", 32'(count), 32'd8);
    flag = 1'b1; scancode = 8'hAA; v_sync = 1'b1;
    step();
    flag = 1'b0;
    chk("fpp_count", 32'(count), 32'd8);
    chk("fpp_ovf", 32'(overflow), 32'd0);
    chk("fpp_code", 32'(out_code), 32'h31);
    v_sync = 1'b0;
    step();
    for (int i = 1; i < 8; i++) frame("fpp_drain", 8'h31 + 8'(i));
    frame("fpp_last", 8'hAA);
    chk("fpp_empty", 32'(count), 32'd0);

    // Wrap-around, ungated streaming
    gate = 1'b0;
    for (int i = 0; i < 20; i++) begin
      flag = 1'b1;
      scancode = 8'h10 + 8'(i);
      step();
      if (i > 0) begin
        chk("wrap_flag", 32'(out_flag), 32'd1);
        chk("wrap_code", 32'(out_code), 32'(8'h10 + 8'(i - 1)));
      end
    end
    flag = 1'b0;
    step();
    chk("wrap_last", 32'(out_code), 32'h23);
    step();
    chk("wrap_empty", 32'(count), 32'd0);
    chk("wrap_ovf", 32'(overflow), 32'd0);

    // Escape code
    gate = 1'b1;
    push(8'h41); push(8'h42); push(8'h43);
    push(8'h76);
`ifdef ESC_FLUSH_EN
    chk("esc_count", 32'(count), 32'd0);
    chk("esc_flag", 32'(out_flag), 32'd1);
    chk("esc_code", 32'(out_code), 32'h45);
    step();
    chk("esc_pulse", 32'(out_flag), 32'd0);
`else
    chk("esc_count", 32'(count), 32'd4);
    frame("esc_q1", 8'h41);
    frame("esc_q2", 8'h42);
    frame("esc_q3", 8'h43);
    frame("esc_q4", 8'h76);
    chk("esc_empty", 32'(count), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule

// File: doc/scancode_frame_queue.md
Name: scancode_frame_queue

Overview:
- Buffers the decoded key-release events (scancode + one-cycle flag) from the PS/2 keyboard decoder.
- Re-issues them to the VGA colour/region controller one event per video frame, at the rising edge of v_sync.
- Colour-register updates therefore land in vertical blanking, not mid-scan.
- Sits between the keyboard decoder and the VGA block, in the 25 MHz pixel-clock domain.

Parameters:
- DEPTH, 8, number of queue entries; must be a power of two, minimum 2.
- AW, 3, pointer width; log2(DEPTH).
- CODE_W, 8, scancode width.

Ports:
- clk  input  1  pixel clock (clk25 domain); all logic on rising edge.
- reset  input  1  asynchronous, active-low reset; asserts immediately, deassertion sampled by clk.
- scancode  input  CODE_W  scancode from the keyboard decoder; valid when flag=1.
- flag  input  1  one-cycle push strobe.
- v_sync  input  1  active-high vertical sync from the sync generator.
- gate  input  1  1 = release one entry per frame; 0 = release one entry per cycle (passthrough).
- clear  input  1  synchronous flush of queue and overflow flag.
- out_code  output  CODE_W  scancode of the last released entry; held until the next release.
- out_flag  output  1  one-cycle pulse when out_code is updated.
- count  output  AW+1  current occupancy, 0..DEPTH.
- overflow  output  1  sticky; set when a push is dropped.

Behaviour:
- Reset (reset=0): all of the following asynchronously.
  - out_code=0, out_flag=0, count=0, overflow=0.
  - Read/write pointers=0; v_sync edge register=0.
- Storage:
  - Circular buffer with wr_ptr/rd_ptr of AW bits; both wrap DEPTH-1 -> 0.
  - count is kept as a separate AW+1 counter. full = (count==DEPTH), empty = (count==0).
- Push:
  - On a cycle with flag=1: if not full, or if a pop occurs in the same cycle, write scancode at wr_ptr and increment wr_ptr.
  - Otherwise drop the code and set overflow=1.
- Frame tick:
  - vs_d <= v_sync every cycle; tick = v_sync & ~vs_d.
  - tick is combinational from the register, so a release happens on the same edge that samples the rising v_sync.
- Pop condition: pop = ~empty & (gate ? tick : 1'b1).
- On pop:
  - out_code <= mem[rd_ptr]; rd_ptr increments; out_flag <= 1 for exactly one cycle.
  - Otherwise out_flag <= 0 and out_code holds.
- Same-cycle push and pop:
  - count is unchanged.
  - When full, the push is accepted and not dropped.
  - When empty, the push is stored but not popped that cycle; empty is evaluated before the push.
- Latency:
  - gate=0: code pushed at edge N appears with out_flag at edge N+1.
  - gate=1: released at the first v_sync rising edge after the push edge.
  - Only one entry is released per frame even if several are queued.
- clear=1 has priority over push and pop on that edge:
  - pointers=0, count=0, overflow=0, out_flag=0; out_code holds.
- gate changing mid-frame: takes effect the next cycle; no pending tick is remembered.
- overflow clears only on reset or clear.
- v_sync held high over many cycles produces exactly one tick.

Optional Feature:
- Macro ESC_FLUSH_EN.
- Defined:
  - A pushed scancode 8'h76 (Esc) is not stored.
  - Instead, on that edge the queue is flushed exactly as for clear; overflow is also cleared.
  - out_code <= 8'h45 and out_flag <= 1 for one cycle, so the downstream block receives the "0 = reset all" key immediately, bypassing gating.
  - If a pop would occur on the same edge, it is cancelled.
- Not defined: 8'h76 is an ordinary code and is queued like any other.

Test Plan:
- Reset check: hold reset=0 with flag pulses present -> out_code=0, out_flag=0, count=0, overflow=0. After release, first push 8'h16 with gate=0 -> out_flag on the next edge, out_code=8'h16.
- Frame gating: gate=1, push 8'h16, 8'h2d, 8'h21 in consecutive cycles -> count=3, no out_flag. Three v_sync rising edges -> out_flag pulses release 8'h16, 8'h2d, 8'h21 in order, one per frame; count returns to 0.
- Full/overflow: gate=1, push 9 codes 8'h01..8'h09 -> count=8, overflow=1, 8'h09 dropped. Then drain -> releases 8'h01..8'h08; overflow stays 1 until clear.
- Full with same-cycle push and pop: fill to 8 entries, assert a push of 8'hAA on the same edge as a v_sync rise -> count stays 8, overflow stays 0, 8'hAA is the last entry drained.
- Wrap-around: gate=0, stream 20 codes 8'h10..8'h23 -> out_code sequence matches exactly, pointers wrap twice, no overflow.
- ESC_FLUSH_EN: queue 3 codes with gate=1, push 8'h76 -> count=0 next edge, out_flag=1 with out_code=8'h45. Without the macro -> count=4 and 8'h76 is released on the 4th tick.
